// File: rtl/idct_1d.sv
// idct_1d: 8-point 1D inverse DCT, 3-stage pipeline, Q8 cosine constants, valid/ready flow control.
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready    input handshake; in_ready is the global pipeline enable
//   coef_in [8*IN_W]      coefficients X0..X7, Xk at [k*IN_W +: IN_W], signed
//   out_valid, out_ready  output handshake
//   samp_out [8*OUT_W]    samples x0..x7, xn at [n*OUT_W +: OUT_W], signed, saturated
module idct_1d #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    coef_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   samp_out
);
    localparam int ACC_W = IN_W + 12;
    localparam logic signed [ACC_W-1:0] C2 = ACC_W'(237);
    localparam logic signed [ACC_W-1:0] C4 = ACC_W'(181);
    localparam logic signed [ACC_W-1:0] C6 = ACC_W'(98);
    // odd-tree constants c1, c3, c5, c7
    localparam logic signed [ACC_W-1:0] CO [4] = '{ACC_W'(251), ACC_W'(213), ACC_W'(142), ACC_W'(50)};
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(256);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(OUT_W-1)));

    logic                    en, v1, v2, v3;
    logic signed [ACC_W-1:0] x  [8];
    logic signed [ACC_W-1:0] pe [6];
    logic signed [ACC_W-1:0] po [4][4];
    logic signed [ACC_W-1:0] e  [4];
    logic signed [ACC_W-1:0] o  [4];
    logic [8*OUT_W-1:0]      samp_d;

    // the whole pipeline freezes only when a finished vector is waiting downstream
    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    for (genvar k = 0; k < 8; k++) begin : g_ext
        assign x[k] = ACC_W'($signed(coef_in[k*IN_W +: IN_W]));
    end

    function automatic logic [OUT_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] y;
        y = (a + HALF) >>> 9;
        return y > MAXV ? MAXV[OUT_W-1:0] : y < MINV ? MINV[OUT_W-1:0] : y[OUT_W-1:0];
    endfunction

    always_comb begin
        samp_d = '0;
        for (int n = 0; n < 4; n++) begin
            samp_d[n*OUT_W +: OUT_W]     = rnd_sat(e[n] + o[n]);
            samp_d[(7-n)*OUT_W +: OUT_W] = rnd_sat(e[n] - o[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            samp_out <= '0;
        end else if (en) begin
            v1       <= in_valid;
            v2       <= v1;
            v3       <= v2;
            samp_out <= samp_d;
        end
    end

    // datapath needs no reset: its contents only matter under a set valid bit
    always_ff @(posedge clk) begin
        if (en) begin
            pe[0] <= C4 * x[0];
            pe[1] <= C4 * x[4];
            pe[2] <= C2 * x[2];
            pe[3] <= C6 * x[2];
            pe[4] <= C2 * x[6];
            pe[5] <= C6 * x[6];
            // po[i][j] = c(2i+1) * X(2j+1)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    po[i][j] <= CO[i] * x[2*j+1];
            e[0] <= pe[0] + pe[1] + pe[2] + pe[5];
            e[1] <= pe[0] - pe[1] + pe[3] - pe[4];
            e[2] <= pe[0] - pe[1] - pe[3] + pe[4];
            e[3] <= pe[0] + pe[1] - pe[2] - pe[5];
            o[0] <= po[0][0] + po[1][1] + po[2][2] + po[3][3];
            o[1] <= po[1][0] - po[3][1] - po[0][2] - po[2][3];
            o[2] <= po[2][0] - po[0][1] + po[3][2] + po[1][3];
            o[3] <= po[3][0] - po[2][1] + po[1][2] - po[0][3];
        end
    end
endmodule

// File: tb/tb_idct_1d.sv
// tb_idct_1d: self-checking bench for idct_1d against a direct matrix-form reference model.
module tb_idct_1d;
    localparam int IN_W  = 12;
    localparam int OUT_W = 9;
    localparam real PI   = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [8*IN_W-1:0]  coef_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [8*OUT_W-1:0] samp_out;
    int                 total = 0;
    int                 bad = 0;

    always #5 clk = ~clk;

    idct_1d #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .coef_in(coef_in), .out_valid(out_valid), .out_ready(out_ready), .samp_out(samp_out)
    );

    function automatic logic [8*IN_W-1:0] pack_c(input int v[8]);
        logic [8*IN_W-1:0] c;
        for (int k = 0; k < 8; k++) c[k*IN_W +: IN_W] = IN_W'(v[k]);
        return c;
    endfunction

    function automatic logic [8*OUT_W-1:0] pack_s(input int v[8]);
        logic [8*OUT_W-1:0] s;
        for (int k = 0; k < 8; k++) s[k*OUT_W +: OUT_W] = OUT_W'(v[k]);
        return s;
    endfunction

    function automatic int samp(input logic [8*OUT_W-1:0] s, input int n);
        logic signed [OUT_W-1:0] t;
        t = s[n*OUT_W +: OUT_W];
        return int'(t);
    endfunction

    // Q8 weight of cos(m*pi/16), folded onto the first quadrant
    function automatic longint cosq(input int m);
        int cq[9];
        cq = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
        return m <= 8 ? cq[m] : m <= 16 ? -cq[16-m] : m <= 24 ? -cq[m-16] : cq[32-m];
    endfunction

    // x[n] = sum_k w(n,k)*X[k], X0 weighted by c4, then round, >>>9, saturate
    function automatic logic [8*OUT_W-1:0] ref_idct(input logic [8*IN_W-1:0] c);
        int r[8];
        for (int n = 0; n < 8; n++) begin
            longint acc, y;
            logic signed [IN_W-1:0] xk;
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                xk = c[k*IN_W +: IN_W];
                acc += (k == 0 ? 64'sd181 : cosq(((2*n+1)*k) % 32)) * longint'(xk);
            end
            y = (acc + 256) >>> 9;
            r[n] = y > 255 ? 255 : y < -256 ? -256 : int'(y);
        end
        return pack_s(r);
    endfunction

    function automatic int rnd(input real r);
        return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic logic [8*IN_W-1:0] rand_coef();
        int v[8];
        for (int k = 0; k < 8; k++)
            v[k] = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 4095)) - 2048
                                             : int'($urandom_range(0, 511)) - 256;
        return pack_c(v);
    endfunction

    task automatic apply_one(input string name, input logic [8*IN_W-1:0] c,
                             input logic [8*OUT_W-1:0] exp, output logic [8*OUT_W-1:0] got);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        coef_in = c;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        got = samp_out;
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL %s latency: got %0d want 3", name, lat);
        end
        total++;
        if (samp_out !== exp) begin
            bad++;
            $display("FAIL %s data: got %h want %h", name, samp_out, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        total++;
        if (samp_out !== '0) begin bad++; $display("FAIL reset samp_out: got %h want 0", samp_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [8*OUT_W-1:0] got;
        apply_one("dc", pack_c('{512, 0, 0, 0, 0, 0, 0, 0}), pack_s('{181, 181, 181, 181, 181, 181, 181, 181}), got);
        apply_one("sat_pos", pack_c('{2047, 0, 0, 0, 0, 0, 0, 0}), pack_s('{255, 255, 255, 255, 255, 255, 255, 255}), got);
        apply_one("sat_neg", pack_c('{-2048, 0, 0, 0, 0, 0, 0, 0}), pack_s('{-256, -256, -256, -256, -256, -256, -256, -256}), got);
        apply_one("odd_x1", pack_c('{0, 256, 0, 0, 0, 0, 0, 0}), pack_s('{126, 107, 71, 25, -25, -71, -106, -125}), got);
    endtask

    task automatic test_random_single();
        logic [8*OUT_W-1:0] got;
        logic [8*IN_W-1:0]  c;
        for (int i = 0; i < 4; i++) begin
            c = rand_coef();
            apply_one("rand_single", c, ref_idct(c), got);
        end
    endtask

    task automatic test_stream(input string name, input int n, input bit bp, input bit gaps, input bit tp);
        logic [8*OUT_W-1:0] q[$];
        logic [8*OUT_W-1:0] held, exp;
        int sent = 0, got = 0, cyc = 0, run = 0, best = 0;
        bit stall = 1'b0, xfer = 1'b0;
        in_valid = 1'b0;
        while (got < n && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (!in_valid || xfer) begin
                in_valid = sent < n && (!gaps || $urandom_range(0, 3) != 0);
                coef_in = rand_coef();
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            xfer = in_valid && in_ready;
            if (xfer) begin
                q.push_back(ref_idct(coef_in));
                sent++;
            end
            if (stall) begin
                total++;
                if (samp_out !== held || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s hold: got %h/%b want %h/1", name, samp_out, out_valid, held);
                end
            end
            if (out_valid && out_ready) begin
                exp = q.size() > 0 ? q.pop_front() : '1;
                total++;
                if (samp_out !== exp) begin
                    bad++;
                    $display("FAIL %s data #%0d: got %h want %h", name, got, samp_out, exp);
                end
                got++;
            end
            run = out_valid ? run + 1 : 0;
            best = run > best ? run : best;
            stall = out_valid && !out_ready;
            held = samp_out;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != n || sent != n) begin
            bad++;
            $display("FAIL %s count: got %0d sent %0d want %0d", name, got, sent, n);
        end
        if (tp) begin
            total++;
            if (best != n) begin
                bad++;
                $display("FAIL %s throughput: got %0d consecutive want %0d", name, best, n);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [8*IN_W-1:0]  c;
        logic [8*OUT_W-1:0] got;
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            coef_in = rand_coef();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst inflight: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midrst stale: got %0d outputs want 0", seen); end
        c = rand_coef();
        apply_one("midrst_next", c, ref_idct(c), got);
    endtask

    task automatic test_roundtrip();
        logic [8*OUT_W-1:0] got;
        int  xs[8], cs[8];
        real s;
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 8; n++) xs[n] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < 8; k++) begin
                s = 0.0;
                for (int n = 0; n < 8; n++) s += xs[n] * $cos((2*n+1)*k*PI/16.0);
                cs[k] = rnd(0.5 * (k == 0 ? 1.0 / $sqrt(2.0) : 1.0) * s);
            end
            apply_one("roundtrip", pack_c(cs), ref_idct(pack_c(cs)), got);
            for (int n = 0; n < 8; n++) begin
                total++;
                if (samp(got, n) - xs[n] > 2 || xs[n] - samp(got, n) > 2) begin
                    bad++;
                    $display("FAIL roundtrip x%0d: got %0d want %0d", n, samp(got, n), xs[n]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_single();
        test_stream("backpressure", 10, 1'b1, 1'b0, 1'b0);
        test_stream("bp_gaps", 30, 1'b1, 1'b1, 1'b0);
        test_stream("throughput", 16, 1'b0, 1'b0, 1'b1);
        test_reset_midstream();
        test_roundtrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
